// File: rtl/spi_master_p.sv
// ---------------------------------------------------------------------------
// spi_master_p
// Parametrised SPI master: one outstanding transfer at a time, runtime
// CPOL/CPHA, configurable word width and bit order, decoded chip selects.
//
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   clkdiv           sclk half-period minus 1, in clk cycles (latched at accept)
//   mode             {CPOL,CPHA} (latched at accept)
//   cs_sel           chip-select index (latched at accept)
//   tx_data          word to send (latched at accept)
//   tx_valid         transfer request; accepted when tx_ready is high
//   tx_ready         high only while idle
//   rx_data          last received word (all ones until the first completion)
//   rx_valid         one-cycle pulse when rx_data updates
//   busy             high whenever a transfer is in flight
//   sclk, mosi, miso SPI bus
//   cs_n             active-low chip selects
// ---------------------------------------------------------------------------
module spi_master_p #(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 16,
    parameter int NUM_CS    = 1,
    parameter int CS_W      = 3,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  clkdiv,
    input  logic [1:0]        mode,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int                BIT_W     = $clog2(DATA_W) + 1;
    localparam logic [BIT_W-1:0]  BITS_FULL = BIT_W'(DATA_W);
    localparam logic [DIV_W-1:0]  CNT_ZERO  = {DIV_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Bit presented on mosi for a (partially shifted) transmit word.
    function automatic logic first_bit(input logic [DATA_W-1:0] word);
        if (LSB_FIRST != 0) begin
            first_bit = word[0];
        end else begin
            first_bit = word[DATA_W-1];
        end
    endfunction

    // Discard the bit already sent so the next one moves into first_bit().
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] word);
        if (LSB_FIRST != 0) begin
            shift_out = {1'b0, word[DATA_W-1:1]};
        end else begin
            shift_out = {word[DATA_W-2:0], 1'b0};
        end
    endfunction

    // Receive assembly mirrors the transmit order so loopback is transparent.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] word,
                                                   input logic              bit_in);
        if (LSB_FIRST != 0) begin
            shift_in = {bit_in, word[DATA_W-1:1]};
        end else begin
            shift_in = {word[DATA_W-2:0], bit_in};
        end
    endfunction

    // Out-of-range selects decode to no active line; the transfer still runs.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        cs_decode = {NUM_CS{1'b1}};
        for (int i = 0; i < NUM_CS; i++) begin
            cs_decode[i] = (sel != CS_W'(i));
        end
    endfunction

    state_t              r_state, w_state;
    logic [DIV_W-1:0]    r_cnt, w_cnt;
    logic [DIV_W-1:0]    r_div, w_div;
    logic                r_cpol, w_cpol;
    logic                r_cpha, w_cpha;
    logic [DATA_W-1:0]   r_tx, w_tx;
    logic [DATA_W-1:0]   r_rx, w_rx;
    logic [BIT_W-1:0]    r_bits, w_bits;
    logic                r_sclk, w_sclk;
    logic                r_mosi, w_mosi;
    logic [NUM_CS-1:0]   r_cs_n, w_cs_n;
    logic [DATA_W-1:0]   r_rx_data, w_rx_data;
    logic                r_rx_valid, w_rx_valid;
    logic                r_busy, w_busy;
    logic                r_tx_ready, w_tx_ready;
    logic                w_lead;
    logic [DATA_W-1:0]   w_tx_next;

    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_div      = r_div;
        w_cpol     = r_cpol;
        w_cpha     = r_cpha;
        w_tx       = r_tx;
        w_rx       = r_rx;
        w_bits     = r_bits;
        w_sclk     = r_sclk;
        w_mosi     = r_mosi;
        w_cs_n     = r_cs_n;
        w_rx_data  = r_rx_data;
        w_rx_valid = 1'b0;
        w_busy     = r_busy;
        w_tx_ready = r_tx_ready;
        w_lead     = 1'b0;
        w_tx_next  = shift_out(r_tx);

        case (r_state)
            S_IDLE: begin
                w_sclk     = mode[1];
                w_mosi     = 1'b1;
                w_cs_n     = {NUM_CS{1'b1}};
                w_busy     = 1'b0;
                w_tx_ready = 1'b1;
                if (tx_valid && r_tx_ready) begin
                    w_state    = S_SETUP;
                    w_cnt      = clkdiv;
                    w_div      = clkdiv;
                    w_cpol     = mode[1];
                    w_cpha     = mode[0];
                    w_tx       = tx_data;
                    w_bits     = {BIT_W{1'b0}};
                    w_mosi     = first_bit(tx_data);
                    w_cs_n     = cs_decode(cs_sel);
                    w_busy     = 1'b1;
                    w_tx_ready = 1'b0;
                end else begin
                    w_state = S_IDLE;
                end
            end

            S_SETUP: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state = S_SHIFT;
                    w_cnt   = r_div;
                end else begin
                    w_cnt = r_cnt - DIV_W'(1'b1);
                end
            end

            S_SHIFT: begin
                if (r_cnt == CNT_ZERO) begin
                    w_cnt  = r_div;
                    w_sclk = ~r_sclk;
                    // A toggle away from the idle level is the leading edge.
                    w_lead = (r_sclk == r_cpol);
                    if (w_lead) begin
                        if (r_cpha == 1'b0) begin
                            w_rx   = shift_in(r_rx, miso);
                            w_bits = r_bits + BIT_W'(1'b1);
                        end else if (r_bits != {BIT_W{1'b0}}) begin
                            // First leading edge re-presents the bit set up in SETUP.
                            w_tx   = w_tx_next;
                            w_mosi = first_bit(w_tx_next);
                        end else begin
                            w_tx = r_tx;
                        end
                    end else begin
                        if (r_cpha == 1'b0) begin
                            if (r_bits == BITS_FULL) begin
                                w_state = S_HOLD;
                            end else begin
                                w_tx   = w_tx_next;
                                w_mosi = first_bit(w_tx_next);
                            end
                        end else begin
                            w_rx   = shift_in(r_rx, miso);
                            w_bits = r_bits + BIT_W'(1'b1);
                            if ((r_bits + BIT_W'(1'b1)) == BITS_FULL) begin
                                w_state = S_HOLD;
                            end else begin
                                w_state = S_SHIFT;
                            end
                        end
                    end
                end else begin
                    w_cnt = r_cnt - DIV_W'(1'b1);
                end
            end

            S_HOLD: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state    = S_DONE;
                    w_cs_n     = {NUM_CS{1'b1}};
                    w_mosi     = 1'b1;
                    w_rx_data  = r_rx;
                    w_rx_valid = 1'b1;
                end else begin
                    w_cnt = r_cnt - DIV_W'(1'b1);
                end
            end

            S_DONE: begin
                w_state    = S_IDLE;
                w_sclk     = mode[1];
                w_mosi     = 1'b1;
                w_cs_n     = {NUM_CS{1'b1}};
                w_busy     = 1'b0;
                w_tx_ready = 1'b1;
            end

            default: begin
                w_state    = S_IDLE;
                w_sclk     = mode[1];
                w_mosi     = 1'b1;
                w_cs_n     = {NUM_CS{1'b1}};
                w_busy     = 1'b0;
                w_tx_ready = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= {DIV_W{1'b0}};
            r_div      <= {DIV_W{1'b0}};
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_tx       <= {DATA_W{1'b0}};
            r_rx       <= {DATA_W{1'b1}};
            r_bits     <= {BIT_W{1'b0}};
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b1;
            r_cs_n     <= {NUM_CS{1'b1}};
            r_rx_data  <= {DATA_W{1'b1}};
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_div      <= w_div;
            r_cpol     <= w_cpol;
            r_cpha     <= w_cpha;
            r_tx       <= w_tx;
            r_rx       <= w_rx;
            r_bits     <= w_bits;
            r_sclk     <= w_sclk;
            r_mosi     <= w_mosi;
            r_cs_n     <= w_cs_n;
            r_rx_data  <= w_rx_data;
            r_rx_valid <= w_rx_valid;
            r_busy     <= w_busy;
            r_tx_ready <= w_tx_ready;
        end
    end

endmodule

// File: tb/tb_spi_master_p.sv
// ---------------------------------------------------------------------------
// tb_spi_master_p
// Two instances: dut_a (MSB first, 4 chip selects, 16-bit divider) and
// dut_b (LSB first, 1 chip select, 2-bit divider). Expected words and their
// due cycles are queued when a request is accepted and compared when
// rx_valid pulses.
// ---------------------------------------------------------------------------
module tb_spi_master_p;

    typedef struct packed {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    // dut_a signals
    logic [15:0] a_clkdiv = 16'd0;
    logic [1:0]  a_mode = 2'b00;
    logic [2:0]  a_cs_sel = 3'd0;
    logic [7:0]  a_tx_data = 8'h00;
    logic        a_tx_valid = 1'b0;
    logic        a_tx_ready, a_rx_valid, a_busy, a_sclk, a_mosi, a_miso;
    logic [7:0]  a_rx_data;
    logic [3:0]  a_cs_n;
    logic        a_loop = 1'b1;
    logic [7:0]  a_slave_pat = 8'h00;
    logic        a_slave_bit = 1'b0;
    int          a_slave_idx = 7;

    // dut_b signals
    logic [1:0]  b_clkdiv = 2'd0;
    logic [1:0]  b_mode = 2'b00;
    logic [2:0]  b_cs_sel = 3'd0;
    logic [7:0]  b_tx_data = 8'h00;
    logic        b_tx_valid = 1'b0;
    logic        b_tx_ready, b_rx_valid, b_busy, b_sclk, b_mosi;
    logic [7:0]  b_rx_data;
    logic [0:0]  b_cs_n;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea_push, ea_pop, eb_push, eb_pop;

    assign a_miso = a_loop ? a_mosi : a_slave_bit;

    spi_master_p #(.DATA_W(8), .DIV_W(16), .NUM_CS(4), .CS_W(3), .LSB_FIRST(0)) dut_a (
        .clk(clk), .rst(rst), .clkdiv(a_clkdiv), .mode(a_mode), .cs_sel(a_cs_sel),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy), .sclk(a_sclk),
        .mosi(a_mosi), .miso(a_miso), .cs_n(a_cs_n)
    );

    spi_master_p #(.DATA_W(8), .DIV_W(2), .NUM_CS(1), .CS_W(3), .LSB_FIRST(1)) dut_b (
        .clk(clk), .rst(rst), .clkdiv(b_clkdiv), .mode(b_mode), .cs_sel(b_cs_sel),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy), .sclk(b_sclk),
        .mosi(b_mosi), .miso(b_mosi), .cs_n(b_cs_n)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SPI slave for dut_a in mode 3: drives the next pattern bit on each leading (falling) edge.
    always @(negedge a_sclk) begin
        if (!a_loop && !a_cs_n[0] && a_slave_idx >= 0) begin
            a_slave_bit = a_slave_pat[a_slave_idx];
            a_slave_idx = a_slave_idx - 1;
        end
    end

    // Scoreboard for dut_a: push on accept, pop and compare on rx_valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_tx_valid && a_tx_ready) begin
                ea_push.data = a_loop ? a_tx_data : a_slave_pat;
                ea_push.due  = cyc + 18 * (int'(a_clkdiv) + 1) + 1;
                q_a.push_back(ea_push);
            end
            if (a_rx_valid) begin
                check_eq("a_sb_pending", (q_a.size() > 0), 1);
                if (q_a.size() > 0) begin
                    ea_pop = q_a.pop_front();
                    check_eq("a_rx_data", a_rx_data, ea_pop.data);
                    check_eq("a_latency", cyc, ea_pop.due);
                end
            end
        end
    end

    // Scoreboard for dut_b.
    always @(negedge clk) begin
        if (!rst) begin
            if (b_tx_valid && b_tx_ready) begin
                eb_push.data = b_tx_data;
                eb_push.due  = cyc + 18 * (int'(b_clkdiv) + 1) + 1;
                q_b.push_back(eb_push);
            end
            if (b_rx_valid) begin
                check_eq("b_sb_pending", (q_b.size() > 0), 1);
                if (q_b.size() > 0) begin
                    eb_pop = q_b.pop_front();
                    check_eq("b_rx_data", b_rx_data, eb_pop.data);
                    check_eq("b_latency", cyc, eb_pop.due);
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] data, input logic [1:0] md, input logic [2:0] cs,
                          input logic [15:0] div, input logic lp, input logic keep);
        logic acc;
        @(posedge clk); #1;
        a_tx_data  = data;
        a_mode     = md;
        a_cs_sel   = cs;
        a_clkdiv   = div;
        a_loop     = lp;
        a_tx_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (a_tx_ready) acc = 1'b1;
        end
        check_eq("a_accept", acc, 1);
        @(posedge clk); #1;
        if (!keep) a_tx_valid = 1'b0;
    endtask

    // Observe dut_a frame until rx_valid; measures cs, sclk edges and level lengths.
    task automatic wait_rx_a(input int h_exp, output int cs0_low, output int rises,
                             output logic [3:0] seen_low, output int bad_iv, output int toggles);
        logic prev;
        logic got;
        int   last_t;
        cs0_low = 0; rises = 0; seen_low = 4'b0000; bad_iv = 0; toggles = 0;
        got = 1'b0; prev = a_sclk; last_t = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (a_rx_valid) begin
                got = 1'b1;
            end else begin
                if (!a_cs_n[0]) cs0_low++;
                seen_low = seen_low | ~a_cs_n;
                if (a_sclk != prev) begin
                    toggles++;
                    if (a_sclk) rises++;
                    if (last_t >= 0 && (cyc - last_t) != h_exp) bad_iv++;
                    last_t = cyc;
                end
                prev = a_sclk;
            end
        end
        check_eq("a_rx_seen", got, 1);
    endtask

    int         cs0_low, rises, bad_iv, toggles, gap, ncap;
    logic [3:0] seen_low;
    logic [7:0] cap;
    logic       got_b, prev_b;

    initial begin
        #1 rst = 1'b1;
        #11;
        // reset values
        check_eq("a_rst_sclk", a_sclk, 0);
        check_eq("a_rst_mosi", a_mosi, 1);
        check_eq("a_rst_cs_n", a_cs_n, 4'hF);
        check_eq("a_rst_rx_data", a_rx_data, 8'hFF);
        check_eq("a_rst_rx_valid", a_rx_valid, 0);
        check_eq("a_rst_busy", a_busy, 0);
        check_eq("a_rst_tx_ready", a_tx_ready, 1);
        check_eq("b_rst_cs_n", b_cs_n, 1);
        check_eq("b_rst_rx_data", b_rx_data, 8'hFF);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // mode 0, H=1, loopback 0xA5
        send_a(8'hA5, 2'b00, 3'd0, 16'd0, 1'b1, 1'b0);
        wait_rx_a(1, cs0_low, rises, seen_low, bad_iv, toggles);
        check_eq("m0_cs0_low_cycles", cs0_low, 18);
        check_eq("m0_sclk_rises", rises, 8);
        check_eq("m0_sclk_toggles", toggles, 16);
        check_eq("m0_level_len", bad_iv, 0);
        check_eq("m0_cs_only0", seen_low, 4'b0001);

        // mode 3, H=3, slave drives 0x3C
        @(posedge clk); #1;
        a_mode = 2'b11; a_loop = 1'b0; a_slave_pat = 8'h3C; a_slave_idx = 7;
        repeat (2) @(posedge clk); #1;
        check_eq("m3_sclk_idle", a_sclk, 1);
        send_a(8'h00, 2'b11, 3'd0, 16'd2, 1'b0, 1'b0);
        wait_rx_a(3, cs0_low, rises, seen_low, bad_iv, toggles);
        check_eq("m3_sclk_toggles", toggles, 16);
        check_eq("m3_sclk_rises", rises, 8);
        check_eq("m3_level_len", bad_iv, 0);
        check_eq("m3_sclk_done", a_sclk, 1);

        // decoded chip selects: in range, then out of range
        send_a(8'h5A, 2'b00, 3'd2, 16'd0, 1'b1, 1'b0);
        wait_rx_a(1, cs0_low, rises, seen_low, bad_iv, toggles);
        check_eq("cs2_lines", seen_low, 4'b0100);
        send_a(8'hC3, 2'b00, 3'd5, 16'd0, 1'b1, 1'b0);
        wait_rx_a(1, cs0_low, rises, seen_low, bad_iv, toggles);
        check_eq("cs5_lines", seen_low, 4'b0000);

        // back-to-back with inputs changed mid-frame
        send_a(8'h11, 2'b00, 3'd0, 16'd0, 1'b1, 1'b1);
        a_tx_data = 8'h22;
        repeat (5) @(posedge clk); #1;
        a_clkdiv = 16'd1;
        @(negedge clk);
        check_eq("b2b_ready_busy", a_tx_ready, 0);
        check_eq("b2b_busy", a_busy, 1);
        wait_rx_a(1, cs0_low, rises, seen_low, bad_iv, toggles);
        check_eq("b2b_old_h", bad_iv, 0);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_cs_n[0] == 1'b0) break;
            gap++;
            if (a_tx_ready) begin
                @(posedge clk); #1 a_tx_valid = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("b2b_cs_gap", gap, 2);
        wait_rx_a(2, cs0_low, rises, seen_low, bad_iv, toggles);
        check_eq("b2b_new_h", bad_iv, 0);

        // dut_b: LSB first, mode 1, maximum divider (H=4), 0x01
        @(posedge clk); #1;
        b_tx_data = 8'h01; b_mode = 2'b01; b_clkdiv = 2'd3; b_tx_valid = 1'b1;
        @(negedge clk);
        check_eq("b_accept_ready", b_tx_ready, 1);
        @(posedge clk); #1 b_tx_valid = 1'b0;
        cap = 8'h00; ncap = 0; got_b = 1'b0; prev_b = b_sclk;
        for (int i = 0; i < 3000 && !got_b; i++) begin
            @(negedge clk);
            if (b_rx_valid) begin
                got_b = 1'b1;
            end else begin
                if (b_sclk && !prev_b) begin
                    if (ncap < 8) cap[ncap] = b_mosi;
                    ncap++;
                end
                prev_b = b_sclk;
            end
        end
        check_eq("b_rx_seen", got_b, 1);
        check_eq("b_mosi_bits", ncap, 8);
        check_eq("b_first_bit", cap[0], 1);
        check_eq("b_rest_bits", cap[7:1], 7'h00);

        // reset in the middle of a mode 0 transfer
        send_a(8'h96, 2'b00, 3'd0, 16'd0, 1'b1, 1'b0);
        repeat (6) @(posedge clk); #2;
        check_eq("rst_mid_busy", a_busy, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_sclk", a_sclk, 0);
        check_eq("rst_mid_cs_n", a_cs_n, 4'hF);
        check_eq("rst_mid_mosi", a_mosi, 1);
        check_eq("rst_mid_busy0", a_busy, 0);
        check_eq("rst_mid_rx_data", a_rx_data, 8'hFF);
        q_a.delete();
        repeat (2) @(posedge clk); #1 rst = 1'b0;
        repeat (40) @(posedge clk); #1;
        check_eq("rst_after_rx_data", a_rx_data, 8'hFF);
        check_eq("rst_after_ready", a_tx_ready, 1);
        check_eq("sb_a_empty", q_a.size(), 0);
        check_eq("sb_b_empty", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master_p.md
Name: spi_master_p

Overview:
Parametrised SPI master, the next generation of the SoC's SPI byte shifter. It adds configurable word width and bit order, runtime SPI mode (CPOL/CPHA), and multiple decoded chip selects. A valid/ready request port and a one-cycle completion pulse replace the bare exchange strobe. It sits between the SoC bus register block and the external pads, with one outstanding transfer at a time.

Parameters:
DATA_W, 8, bits per transfer (2..32)
DIV_W, 16, width of the clock divider input/counter
NUM_CS, 1, number of chip-select outputs (1..8)
CS_W, 3, width of cs_sel; must satisfy 2**CS_W >= NUM_CS
LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB first

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
clkdiv  input  DIV_W  half-period of sclk, minus 1, in clk cycles
mode  input  2  {CPOL,CPHA}; sampled at request accept
cs_sel  input  CS_W  chip-select index; sampled at accept
tx_data  input  DATA_W  word to send
tx_valid  input  1  transfer request
tx_ready  output  1  high only in IDLE
rx_data  output  DATA_W  last received word
rx_valid  output  1  one-cycle pulse at transfer completion
busy  output  1  high in any state other than IDLE
sclk  output  1  SPI clock
mosi  output  1  SPI data out
miso  input  1  SPI data in
cs_n  output  NUM_CS  active-low chip selects

Behaviour:
- Reset (asynchronous, any state): state=IDLE, sclk=0, mosi=1, cs_n=all 1, rx_data=all 1, rx_valid=0, busy=0, tx_ready=1, divider=0.
- rx_data reads all-ones until the first completed transfer, then holds the last received word until the next completion.
- Accept happens when tx_valid && tx_ready on a rising edge. At accept, latch tx_data, mode, cs_sel and clkdiv. Later changes to these inputs do not affect the transfer in flight.
- H = clkdiv_latched + 1 clk cycles. The divider counts H-1 down to 0. Each state step and each sclk toggle happens on the cycle the counter reads 0.
- IDLE: sclk=CPOL of the current mode input; mosi=1; cs_n all high. On accept, go to SETUP.
- SETUP (H cycles): cs_n[cs_sel]=0. If cs_sel >= NUM_CS, no cs_n line drops and the transfer still runs. CPHA=0: mosi is driven with the first bit. CPHA=1: mosi is held at the first bit value as well. Then go to SHIFT.
- SHIFT (2*DATA_W half-periods): sclk toggles every H cycles, starting from CPOL.
  - CPHA=0: sample miso on the leading edge; drive the next bit on the trailing edge.
  - CPHA=1: drive the bit on the leading edge; sample on the trailing edge.
  - Bit counter width is clog2(DATA_W)+1. Leave SHIFT after the DATA_W-th sample, once sclk is back at CPOL.
- HOLD (H cycles): sclk=CPOL; cs_n stays asserted; mosi holds the last bit.
- DONE (1 cycle): cs_n all high; rx_data updates; rx_valid=1; then go to IDLE. tx_ready rises the cycle after DONE.
- Received bits are assembled in the same order as LSB_FIRST, so a loopback returns tx_data unchanged.
- Latency from the accept edge to the rx_valid cycle is (2*DATA_W+2)*H + 1 clk cycles.
- Back-to-back transfers: tx_valid held high is accepted again on the first IDLE cycle. cs_n is deasserted for at least 2 cycles (DONE + IDLE) between transfers.
- tx_valid asserted while busy: tx_ready=0, the request is not accepted and no state is altered.
- clkdiv=0 gives H=1, so sclk = clk/2. The maximum clkdiv gives H = 2**DIV_W with no overflow, since the counter is DIV_W bits.
- Reset mid-transfer: the transfer is aborted immediately, all outputs take their reset values, and no rx_valid is produced.

Test Plan:
- DATA_W=8, mode 0, clkdiv=0, mosi looped to miso, tx_data=0xA5 -> rx_valid exactly 19 cycles after accept; rx_data=0xA5; sclk shows 8 rising edges; cs_n[0] low throughout the frame.
- Mode 3, clkdiv=2 -> sclk idles high; each sclk level lasts 3 cycles; miso driven with the pattern 0x3C is captured on rising edges; rx_data=0x3C; latency = 18*3+1 = 55 cycles.
- LSB_FIRST=1, tx_data=0x01, mode 1 -> first mosi bit=1 and the remaining 7 bits=0; loopback rx_data=0x01.
- NUM_CS=4, cs_sel=2, then cs_sel=5 -> only cs_n[2] drops in the first transfer; all cs_n stay high in the second, yet rx_valid still pulses.
- tx_valid held high for two words 0x11, 0x22, with clkdiv changed mid-frame -> the first frame keeps the old H; cs_n is high for >= 2 cycles between frames; two rx_valid pulses with the correct data.
- Assert rst at cycle 7 of a mode 0 transfer -> sclk=0, cs_n all 1, mosi=1, busy=0 in the same cycle; no rx_valid; rx_data=0xFF.
